// File: rtl/instr_mem_loader.sv
// Instruction store for the fetch stage. Reads are combinational by PC.
// A byte-stream loader writes the store and freezes fetch while it runs.
module instr_mem_loader #(
    parameter int          DEPTH    = 256,
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [15:0]       instruction,
    output logic              freeze,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [15:0]      mem [DEPTH];
    logic [7:0]       lo;
    logic [LEN_W-1:0] wptr;
    logic [LEN_W-1:0] len;

    logic             len_ok;
    logic             hs;
    logic             last_word;

    // A load needs at least one word and must fit the store, so wptr never wraps
    assign len_ok    = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
    assign hs        = byte_valid & byte_ready;
    assign last_word = (wptr + LEN_W'(1)) == len;

    // Zero-latency read; PCs beyond the store return a NOP
    assign instruction = (pc < 32'(DEPTH)) ? mem[pc[ADDR_W-1:0]] : NOP_WORD;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (load_start && len_ok) state_nx = LOAD_LO;
            end
            LOAD_LO: begin
                if (hs) state_nx = LOAD_HI;
            end
            LOAD_HI: begin
                if (hs) state_nx = last_word ? DONE : LOAD_LO;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        freeze     = 1'b0;
        byte_ready = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: ;
            LOAD_LO, LOAD_HI: begin
                freeze     = 1'b1;
                byte_ready = 1'b1;
            end
            DONE: begin
                freeze    = 1'b1;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Loader datapath: length latch, word pointer, low byte, error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            lo       <= '0;
            wptr     <= '0;
            len      <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            len  <= load_len;
                            wptr <= '0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                LOAD_LO: begin
                    if (hs) lo <= byte_data;
                end
                LOAD_HI: begin
                    if (hs) wptr <= wptr + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Store write; contents survive reset, and a reset edge suppresses the write
    always_ff @(posedge clk) begin
        if (!reset && state == LOAD_HI && hs)
            mem[wptr[ADDR_W-1:0]] <= {byte_data, lo};
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: scoreboard of written words.
module tb_instr_mem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    typedef struct {
        int          addr;
        logic [15:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       pc;
    logic [15:0]       instruction;
    logic              freeze;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              load_done;
    logic              load_err;

    int tests = 0;
    int fails = 0;

    logic [7:0]  bq[$];
    exp_t        exp_q[$];
    logic [15:0] model [DEPTH];

    // Results of the last run_load
    int rdy_cyc, done_cnt, err_cnt, frz_cyc, sent;
    bit timed_out;

    instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(16'h0000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instruction(instruction),
        .freeze(freeze), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a load of len words from bq; stop early once `limit` bytes were taken.
    // Pushes each completed word to the scoreboard as its high byte is accepted.
    task automatic run_load(input int len, input bit toggle, input int limit, input bit poke);
        int cyc;
        bit bv;
        rdy_cyc = 0; done_cnt = 0; err_cnt = 0; frz_cyc = 0; sent = 0; timed_out = 0;
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        step();
        load_start = 1'b0;
        cyc = 0;
        while (freeze) begin
            if (cyc >= 2000) begin
                timed_out = 1;
                break;
            end
            bv = toggle ? cyc[0] : 1'b1;
            if (sent >= limit) bv = 1'b0;
            byte_valid = bv;
            byte_data  = bv ? bq[sent] : 8'hxx;
            load_start = poke && (cyc == 2);
            load_len   = poke ? '0 : load_len;
            #1;
            frz_cyc++;
            if (byte_ready) rdy_cyc++;
            if (load_done)  done_cnt++;
            if (load_err)   err_cnt++;
            if (byte_ready && bv) begin
                if (sent[0]) begin
                    exp_q.push_back('{addr: sent >> 1, data: {bq[sent], bq[sent-1]}});
                    model[sent >> 1] = {bq[sent], bq[sent-1]};
                end
                sent++;
            end
            step();
            cyc++;
            if (limit < bq.size() && sent == limit) break;
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
        if (err_cnt == 0 && load_err) err_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = '0; load_start = 0; load_len = '0; byte_valid = 0; byte_data = '0;
        step(); step();
        reset = 1'b0;
        tests++;
        if (freeze !== 1'b0 || byte_ready !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            $display("FAIL reset_outputs: got frz=%b rdy=%b done=%b err=%b, want all 0",
                     freeze, byte_ready, load_done, load_err);
            fails++;
        end
    endtask

    task automatic test_basic_load(input bit toggle);
        bq = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_load(2, toggle, 4, 0);
        tests++;
        if (timed_out) begin $display("FAIL load_timeout: toggle=%0d", toggle); fails++; end
        tests++;
        if (rdy_cyc !== (toggle ? 8 : 4)) begin
            $display("FAIL ready_cycles: got %0d want %0d", rdy_cyc, toggle ? 8 : 4); fails++;
        end
        tests++;
        if (done_cnt !== 1) begin $display("FAIL done_pulses: got %0d want 1", done_cnt); fails++; end
        tests++;
        if (frz_cyc !== (toggle ? 9 : 5)) begin
            $display("FAIL freeze_cycles: got %0d want %0d", frz_cyc, toggle ? 9 : 5); fails++;
        end
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            pc = 32'(e.addr);
            #1;
            tests++;
            if (instruction !== e.data) begin
                $display("FAIL store_word[%0d]: got %h want %h", e.addr, instruction, e.data); fails++;
            end
        end
    endtask

    task automatic test_bad_len(input int len);
        load_start = 1'b1;
        load_len   = (ADDR_W+1)'(len);
        step();
        load_start = 1'b0;
        tests++;
        if (load_err !== 1'b1 || freeze !== 1'b0 || byte_ready !== 1'b0) begin
            $display("FAIL bad_len_%0d: got err=%b frz=%b rdy=%b want 1 0 0", len, load_err, freeze, byte_ready);
            fails++;
        end
        step();
        tests++;
        if (load_err !== 1'b0 || freeze !== 1'b0) begin
            $display("FAIL bad_len_pulse_%0d: got err=%b frz=%b want 0 0", len, load_err, freeze); fails++;
        end
    endtask

    task automatic test_pc_range();
        bq.delete();
        for (int i = 0; i < 5; i++) begin
            bq.push_back(8'(8'h10 + i));
            bq.push_back(8'hA0);
        end
        bq.push_back(8'hEF);
        bq.push_back(8'hBE);
        run_load(6, 0, 12, 0);
        tests++;
        if (timed_out || done_cnt !== 1) begin
            $display("FAIL beef_load: got done=%0d timeout=%0d want 1 0", done_cnt, timed_out); fails++;
        end
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            pc = 32'(e.addr);
            #1;
            tests++;
            if (instruction !== e.data) begin
                $display("FAIL beef_word[%0d]: got %h want %h", e.addr, instruction, e.data); fails++;
            end
        end
        pc = 32'd300;
        #1;
        tests++;
        if (instruction !== 16'h0000) begin $display("FAIL pc_300: got %h want 0000", instruction); fails++; end
        pc = 32'd256;
        #1;
        tests++;
        if (instruction !== 16'h0000) begin $display("FAIL pc_256: got %h want 0000", instruction); fails++; end
        pc = 32'h0001_0005;
        #1;
        tests++;
        if (instruction !== 16'h0000) begin $display("FAIL pc_high: got %h want 0000", instruction); fails++; end
        pc = 32'd5;
        #1;
        tests++;
        if (instruction !== 16'hBEEF) begin $display("FAIL pc_5: got %h want beef", instruction); fails++; end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] old1;
        old1 = model[1];
        bq = '{8'hCD, 8'hAB, 8'h11, 8'h22};
        run_load(2, 0, 3, 0);
        reset = 1'b1;
        step();
        tests++;
        if (freeze !== 1'b0 || byte_ready !== 1'b0 || load_done !== 1'b0) begin
            $display("FAIL reset_mid: got frz=%b rdy=%b done=%b want 0 0 0", freeze, byte_ready, load_done);
            fails++;
        end
        reset = 1'b0;
        step();
        tests++;
        if (done_cnt !== 0 || load_done !== 1'b0) begin
            $display("FAIL reset_mid_done: got %0d pulses want 0", done_cnt); fails++;
        end
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            pc = 32'(e.addr);
            #1;
            tests++;
            if (instruction !== e.data) begin
                $display("FAIL reset_kept[%0d]: got %h want %h", e.addr, instruction, e.data); fails++;
            end
        end
        pc = 32'd1;
        #1;
        tests++;
        if (instruction !== old1) begin $display("FAIL reset_mem1: got %h want %h", instruction, old1); fails++; end
    endtask

    task automatic test_ignored_start();
        bq = '{8'h0D, 8'hF0, 8'hAD, 8'hDE};
        run_load(2, 0, 4, 1);
        tests++;
        if (err_cnt !== 0 || done_cnt !== 1 || timed_out) begin
            $display("FAIL ignored_start: got err=%0d done=%0d want 0 1", err_cnt, done_cnt); fails++;
        end
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            pc = 32'(e.addr);
            #1;
            tests++;
            if (instruction !== e.data) begin
                $display("FAIL ignored_word[%0d]: got %h want %h", e.addr, instruction, e.data); fails++;
            end
        end
    endtask

    task automatic test_full_depth();
        int bad;
        bq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            bq.push_back(8'(i * 7 + 3));
            bq.push_back(8'(~i));
        end
        run_load(DEPTH, 0, 2 * DEPTH, 0);
        tests++;
        if (timed_out || done_cnt !== 1 || rdy_cyc !== 2 * DEPTH) begin
            $display("FAIL full_load: got done=%0d rdy=%0d want 1 %0d", done_cnt, rdy_cyc, 2 * DEPTH); fails++;
        end
        bad = 0;
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            pc = 32'(e.addr);
            #1;
            tests++;
            if (instruction !== e.data) begin
                fails++;
                if (bad < 4) $display("FAIL full_word[%0d]: got %h want %h", e.addr, instruction, e.data);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load(0);
        test_basic_load(1);
        test_bad_len(0);
        test_bad_len(DEPTH + 1);
        test_pc_range();
        test_basic_load(0);
        test_reset_mid_load();
        test_ignored_start();
        test_full_depth();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
